// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit control stage.
// Handshake, baud divider, frame FSM and shift-register strobes.
module uart_tx_ctrl #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 1,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   input  logic             piso_bit,
   output logic             load_bit,
   output logic             shift_bit,
   output logic             tx,
   output logic             busy,
   output logic             tx_done
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t        state_q;
   logic [CW-1:0] baud_q;
   logic [BW-1:0] bit_q;
   logic          stop_q;
   logic          par_q;

   logic bit_end;
   logic last_data;
   logic last_stop;

   assign bit_end   = (baud_q == CW'(CLKS_PER_BIT - 1));
   assign last_data = (bit_q == BW'(WIDTH - 1));
   assign last_stop = (stop_q == 1'(STOP_BITS - 1));

   // Frame FSM, baud divider, bit/stop indices and parity capture
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         par_q   <= 1'b0;
      end else begin
         if (state_q == S_IDLE || bit_end) begin
            baud_q <= '0;
         end else begin
            baud_q <= baud_q + 1'b1;
         end
         unique case (state_q)
            S_IDLE: begin
               if (tx_valid) begin
                  state_q <= S_START;
                  par_q   <= (^tx_data) ^ PARITY_ODD[0];
               end
            end
            S_START: begin
               if (bit_end) begin
                  state_q <= S_DATA;
                  bit_q   <= '0;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  if (last_data) begin
                     bit_q   <= '0;
                     stop_q  <= 1'b0;
                     state_q <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                  end else begin
                     bit_q <= bit_q + 1'b1;
                  end
               end
            end
            S_PARITY: begin
               if (bit_end) begin
                  state_q <= S_STOP;
                  stop_q  <= 1'b0;
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  if (last_stop) begin
                     state_q <= S_IDLE;
                     stop_q  <= 1'b0;
                  end else begin
                     stop_q <= stop_q + 1'b1;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Output decode of registered state; the line mux follows piso_bit in DATA
   always_comb begin
      tx_ready  = 1'b0;
      load_bit  = 1'b0;
      shift_bit = 1'b0;
      tx        = 1'b1;
      busy      = 1'b1;
      tx_done   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            tx_ready = 1'b1;
            busy     = 1'b0;
            load_bit = tx_valid;
         end
         S_START: tx = 1'b0;
         S_DATA: begin
            tx        = piso_bit;
            shift_bit = bit_end;
         end
         S_PARITY: tx = par_q;
         S_STOP:   tx_done = bit_end & last_stop;
         default: begin
            tx   = 1'b1;
            busy = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: scoreboard bench for uart_tx_ctrl.
// Three builds: even parity, odd parity, no parity with 2 stops.
module tb_uart_tx_ctrl;

   localparam int CPB = 4;
   localparam int NB  = 11;

   logic       clk;
   logic       rst_n;
   logic [7:0] td [3];
   logic [2:0] valid;
   logic [2:0] ready;
   logic [2:0] piso;
   logic [2:0] load;
   logic [2:0] shift;
   logic [2:0] txl;
   logic [2:0] busy;
   logic [2:0] done;
   logic [7:0] sr [3];

   logic [NB-1:0] q0[$];
   logic [NB-1:0] q1[$];
   logic [NB-1:0] q2[$];

   int nchk;
   int npass;

   uart_tx_ctrl #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1),
                  .PARITY_ODD(0), .STOP_BITS(1)) u0 (
      .clk(clk), .rst(rst_n), .tx_data(td[0]), .tx_valid(valid[0]),
      .tx_ready(ready[0]), .piso_bit(piso[0]), .load_bit(load[0]),
      .shift_bit(shift[0]), .tx(txl[0]), .busy(busy[0]), .tx_done(done[0]));

   uart_tx_ctrl #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1),
                  .PARITY_ODD(1), .STOP_BITS(1)) u1 (
      .clk(clk), .rst(rst_n), .tx_data(td[1]), .tx_valid(valid[1]),
      .tx_ready(ready[1]), .piso_bit(piso[1]), .load_bit(load[1]),
      .shift_bit(shift[1]), .tx(txl[1]), .busy(busy[1]), .tx_done(done[1]));

   uart_tx_ctrl #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0),
                  .PARITY_ODD(0), .STOP_BITS(2)) u2 (
      .clk(clk), .rst(rst_n), .tx_data(td[2]), .tx_valid(valid[2]),
      .tx_ready(ready[2]), .piso_bit(piso[2]), .load_bit(load[2]),
      .shift_bit(shift[2]), .tx(txl[2]), .busy(busy[2]), .tx_done(done[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shift register models, one per build
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 3; k++) sr[k] <= '0;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (load[k]) sr[k] <= td[k];
            else if (shift[k]) sr[k] <= sr[k] >> 1;
         end
      end
   end

   assign piso = {sr[2][0], sr[1][0], sr[0][0]};

   task automatic chk(input bit ok, input string nm,
                      input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (ok) npass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   function automatic logic [NB-1:0] mk(input int i, input logic [7:0] d,
                                        input logic par);
      if (i == 2) return {2'b11, d, 1'b0};
      return {1'b1, par, d, 1'b0};
   endfunction

   function automatic int qsize(input int i);
      if (i == 0) return q0.size();
      if (i == 1) return q1.size();
      return q2.size();
   endfunction

   task automatic qpush(input int i, input logic [NB-1:0] f);
      if (i == 0) q0.push_back(f);
      else if (i == 1) q1.push_back(f);
      else q2.push_back(f);
   endtask

   task automatic qpop(input int i, output logic [NB-1:0] f);
      if (i == 0) f = q0.pop_front();
      else if (i == 1) f = q1.pop_front();
      else f = q2.pop_front();
   endtask

   // Monitor: each load_bit starts a frame compared bit by bit
   task automatic mon(input int i);
      logic [NB-1:0] e;
      int bad;
      bit abort;
      bit se;
      bit de;
      forever begin
         @(negedge clk);
         while (rst_n && load[i]) begin
            chk(qsize(i) > 0, $sformatf("u%0d unexpected load", i),
                32'(qsize(i)), 32'd1);
            if (qsize(i) > 0) qpop(i, e);
            else e = '1;
            abort = 1'b0;
            for (int b = 0; b < NB && !abort; b++) begin
               bad = 0;
               for (int c = 0; c < CPB && !abort; c++) begin
                  @(negedge clk);
                  if (!rst_n) begin
                     abort = 1'b1;
                  end else begin
                     se = (b >= 1 && b <= 8 && c == CPB - 1);
                     de = (b == NB - 1 && c == CPB - 1);
                     if (txl[i] !== e[b]) bad++;
                     if (load[i] !== 1'b0) bad++;
                     if (shift[i] !== se) bad++;
                     if (done[i] !== de) bad++;
                     if (busy[i] !== 1'b1) bad++;
                     if (ready[i] !== 1'b0) bad++;
                  end
               end
               if (!abort)
                  chk(bad == 0, $sformatf("u%0d frame bit %0d", i, b),
                      32'(bad), 32'd0);
            end
            if (!abort) begin
               @(negedge clk);
               chk(ready[i] === 1'b1 && txl[i] === 1'b1 &&
                   busy[i] === 1'b0 && done[i] === 1'b0,
                   $sformatf("u%0d post-frame idle", i),
                   {28'd0, ready[i], txl[i], busy[i], done[i]}, 32'hc);
            end
         end
      end
   endtask

   initial mon(0);
   initial mon(1);
   initial mon(2);

   // Issue one byte; expected frame goes to the scoreboard first
   task automatic send(input int i, input logic [7:0] d, input logic par,
                       input bit hold);
      int n;
      qpush(i, mk(i, d, par));
      td[i]    = d;
      valid[i] = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!load[i] && n < 200);
      chk(load[i] === 1'b1, $sformatf("u%0d accept", i),
          32'(load[i]), 32'd1);
      @(posedge clk);
      #1;
      if (!hold) valid[i] = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q0.size() + q1.size() + q2.size() != 0 || busy != 3'b000)
             && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk(n < 2000, "drain", 32'(n), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      nchk  = 0;
      npass = 0;
      rst_n = 1'b0;
      valid = '0;
      for (int k = 0; k < 3; k++) td[k] = '0;
      #1;
      chk(txl === 3'b111 && ready === 3'b111 && busy === 3'b000 &&
          load === 3'b000 && shift === 3'b000 && done === 3'b000,
          "reset outputs", {txl, ready, busy, load, shift, done},
          32'b111_111_000_000_000_000);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      send(0, 8'hA5, 1'b0, 1'b0);
      drain();
      send(1, 8'h00, 1'b1, 1'b0);
      send(1, 8'hFF, 1'b1, 1'b0);
      send(0, 8'h01, 1'b1, 1'b0);
      send(2, 8'hA5, 1'b0, 1'b0);
      drain();

      send(0, 8'h55, 1'b0, 1'b1);
      send(0, 8'h0F, 1'b0, 1'b0);
      drain();

      send(0, 8'hA5, 1'b0, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      td[0]    = 8'h3C;
      valid[0] = 1'b1;
      @(negedge clk);
      chk(ready[0] === 1'b0 && load[0] === 1'b0, "mid-frame valid ignored",
          {30'd0, ready[0], load[0]}, 32'd0);
      @(posedge clk);
      #1;
      valid[0] = 1'b0;
      drain();

      send(0, 8'h81, 1'b0, 1'b0);
      repeat (17) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk(txl[0] === 1'b1 && ready[0] === 1'b1 && busy[0] === 1'b0 &&
          shift[0] === 1'b0 && load[0] === 1'b0, "async reset mid-frame",
          {27'd0, txl[0], ready[0], busy[0], shift[0], load[0]},
          32'b11000);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      send(0, 8'h81, 1'b0, 1'b0);
      send(2, 8'h3C, 1'b0, 1'b0);
      drain();

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
